dmem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory load/store interface. Accepts one load/store request from the

---
 rtl/dmem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Initiator side of the data-memory load/store port. Takes one request at a
// time from the MEM stage, screens it for illegal size and misalignment, pulses
// a single registered read or write strobe toward data_memory, waits out the
// one-cycle synchronous read latency, formats load data and holds the response
// until the consumer takes it.

module dmem_access_ctrl #(
  parameter int XLEN = 32,
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [63:0]     req_wdata,
  input  logic            req_is_store,
  input  logic            req_is_fp,
  input  logic [2:0]      req_funct3,
  output logic [XLEN-1:0] mem_addr,
  output logic [63:0]     mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_funct3,
  input  logic [63:0]     mem_read_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_data,
  output logic [1:0]      resp_fault
);

  localparam bit IS_RV32   = (XLEN == 32);
  localparam bit FP_WORD   = (FLEN >= 32);
  localparam bit FP_DOUBLE = (FLEN == 64);
  localparam bit NAN_BOX   = (FLEN == 64);

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_SIZE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LOAD_DATA,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        is_store_q;
  logic        is_fp_q;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [1:0]  req_fault;
  logic [63:0] load_fmt;

  assign accept = (state == IDLE) && req_valid;

  // Classify the incoming request; an illegal size hides any alignment problem
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_is_store && req_funct3[2])                          illegal = 1'b1;
    if (!req_is_store && (req_funct3 == 3'b111))                illegal = 1'b1;
    if (!req_is_fp && (req_funct3 == 3'b011) && IS_RV32)        illegal = 1'b1;
    if (!req_is_store && (req_funct3 == 3'b110) && IS_RV32)     illegal = 1'b1;
    if (req_is_fp && (req_funct3 != 3'b010) && (req_funct3 != 3'b011))
                                                                illegal = 1'b1;
    if (req_is_fp && (req_funct3 == 3'b010) && !FP_WORD)        illegal = 1'b1;
    if (req_is_fp && (req_funct3 == 3'b011) && !FP_DOUBLE)      illegal = 1'b1;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    if (illegal)         req_fault = FAULT_SIZE;
    else if (misaligned) req_fault = FAULT_ALIGN;
    else                 req_fault = FAULT_NONE;
  end

  // Shape raw memory data: NaN-box single floats, clip integers to 32 bits on RV32
  always_comb begin
    load_fmt = mem_read_data;
    if (is_fp_q && (mem_funct3 == 3'b010) && NAN_BOX)
      load_fmt = {32'hFFFF_FFFF, mem_read_data[31:0]};
    else if (!is_fp_q && IS_RV32)
      load_fmt = {32'h0000_0000, mem_read_data[31:0]};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: faults skip straight to the response
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (req_valid) next_state = (req_fault != FAULT_NONE) ? RESP : ISSUE;
      ISSUE:     next_state = is_store_q ? RESP : LOAD_DATA;
      LOAD_DATA: next_state = RESP;
      RESP:      if (resp_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Request capture, single-cycle strobes and response data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_store_q     <= 1'b0;
      is_fp_q        <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_funct3     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      resp_data      <= '0;
      resp_fault     <= FAULT_NONE;
    end else begin
      mem_read  <= accept && (req_fault == FAULT_NONE) && !req_is_store;
      mem_write <= accept && (req_fault == FAULT_NONE) && req_is_store;
      if (accept) begin
        is_store_q <= req_is_store;
        is_fp_q    <= req_is_fp;
        resp_data  <= '0;
        resp_fault <= req_fault;
        if (req_fault == FAULT_NONE) begin
          mem_addr       <= req_addr;
          mem_write_data <= req_wdata;
          mem_funct3     <= req_funct3;
        end
      end
      if (state == LOAD_DATA) resp_data <= load_fmt;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
// Directed vector bench for dmem_access_ctrl (XLEN=32, FLEN=64) with a small
// byte-addressed data_memory model behind it.

module tb_dmem_access_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_is_store;
  logic        req_is_fp;
  logic [2:0]  req_funct3;
  logic [31:0] mem_addr;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_fault;

  int checks = 0;
  int fails  = 0;

  int rd_total = 0;
  int wr_total = 0;
  int rd_run   = 0;
  int wr_run   = 0;
  int max_run  = 0;

  logic [7:0] mem [0:4095];

  typedef struct {
    string       name;
    logic        is_store;
    logic        is_fp;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic [1:0]  exp_fault;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  dmem_access_ctrl #(.XLEN(32), .FLEN(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_is_store   (req_is_store),
    .req_is_fp      (req_is_fp),
    .req_funct3     (req_funct3),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_funct3     (mem_funct3),
    .mem_read_data  (mem_read_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_fault     (resp_fault)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the handshake wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mem_load(input logic [31:0] a, input logic [2:0] f3);
    logic [63:0] raw;
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[(int'(a[11:0]) + i) & 4095];
    case (f3[1:0])
      2'b00:   return f3[2] ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   return f3[2] ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   return f3[2] ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  // data_memory model: synchronous write, one-cycle registered read
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem_read_data = '0;
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 8; i++)
        if (i < (1 << mem_funct3[1:0]))
          mem[(int'(mem_addr[11:0]) + i) & 4095] <= mem_write_data[8*i +: 8];
    if (mem_read) mem_read_data <= mem_load(mem_addr, mem_funct3);
  end

  // Strobe monitor: counts pulses and longest run of consecutive high cycles
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_read)  begin rd_total++; rd_run++; end else rd_run = 0;
      if (mem_write) begin wr_total++; wr_run++; end else wr_run = 0;
      if (rd_run > max_run) max_run = rd_run;
      if (wr_run > max_run) max_run = wr_run;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction: present, accept, wait for response, optionally stall, release
  task automatic applyStimulus(input vec_t v);
    int          lat;
    int          rd0;
    int          wr0;
    logic [63:0] held_data;
    logic [1:0]  held_fault;
    @(negedge clk);
    checkOutput({v.name, ".ready"}, 64'(req_ready), 64'd1);
    rd0          = rd_total;
    wr0          = wr_total;
    req_valid    = 1'b1;
    req_is_store = v.is_store;
    req_is_fp    = v.is_fp;
    req_funct3   = v.funct3;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    resp_ready   = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checkOutput({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    checkOutput({v.name, ".data"}, resp_data, v.exp_data);
    checkOutput({v.name, ".fault"}, 64'(resp_fault), 64'(v.exp_fault));
    held_data  = resp_data;
    held_fault = resp_fault;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      checkOutput({v.name, ".hold"},
                  64'({resp_valid, req_ready, resp_data == held_data, resp_fault == held_fault}),
                  64'(4'b1011));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    checkOutput({v.name, ".release"}, 64'({resp_valid, req_ready}), 64'(2'b01));
    checkOutput({v.name, ".reads"}, 64'(rd_total - rd0),
                64'((v.exp_fault == 2'b00 && !v.is_store) ? 1 : 0));
    checkOutput({v.name, ".writes"}, 64'(wr_total - wr0),
                64'((v.exp_fault == 2'b00 && v.is_store) ? 1 : 0));
  endtask

  initial begin
    vec_t after_rst;

    //          name        st fp f3      addr          wdata                     exp_data                 flt  lat hold
    vecs.push_back('{"sw",      1, 0, 3'b010, 32'h100, 64'h1111_2222_DEAD_BEEF, 64'h0,                   2'b00, 2, 0});
    vecs.push_back('{"lw",      0, 0, 3'b010, 32'h100, 64'h0,                   64'h0000_0000_DEAD_BEEF, 2'b00, 3, 0});
    vecs.push_back('{"sb",      1, 0, 3'b000, 32'h203, 64'h5555_6666_7777_8880, 64'h0,                   2'b00, 2, 0});
    vecs.push_back('{"lb",      0, 0, 3'b000, 32'h203, 64'h0,                   64'h0000_0000_FFFF_FF80, 2'b00, 3, 0});
    vecs.push_back('{"lbu",     0, 0, 3'b100, 32'h203, 64'h0,                   64'h0000_0000_0000_0080, 2'b00, 3, 0});
    vecs.push_back('{"lw_mis",  0, 0, 3'b010, 32'h102, 64'h0,                   64'h0,                   2'b01, 1, 0});
    vecs.push_back('{"fsd",     1, 1, 3'b011, 32'h300, 64'h4009_21FB_5444_2D18, 64'h0,                   2'b00, 2, 0});
    vecs.push_back('{"fld",     0, 1, 3'b011, 32'h300, 64'h0,                   64'h4009_21FB_5444_2D18, 2'b00, 3, 0});
    vecs.push_back('{"ld_rv32", 0, 0, 3'b011, 32'h300, 64'h0,                   64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"ld_prio", 0, 0, 3'b011, 32'h301, 64'h0,                   64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"fsw",     1, 1, 3'b010, 32'h310, 64'hABCD_0123_3F80_0000, 64'h0,                   2'b00, 2, 0});
    vecs.push_back('{"flw",     0, 1, 3'b010, 32'h310, 64'h0,                   64'hFFFF_FFFF_3F80_0000, 2'b00, 3, 5});
    vecs.push_back('{"sh",      1, 0, 3'b001, 32'h402, 64'h0000_0000_1234_BEEF, 64'h0,                   2'b00, 2, 0});
    vecs.push_back('{"lh",      0, 0, 3'b001, 32'h402, 64'h0,                   64'h0000_0000_FFFF_BEEF, 2'b00, 3, 0});
    vecs.push_back('{"lhu",     0, 0, 3'b101, 32'h402, 64'h0,                   64'h0000_0000_0000_BEEF, 2'b00, 3, 0});
    vecs.push_back('{"lh_mis",  0, 0, 3'b001, 32'h401, 64'h0,                   64'h0,                   2'b01, 1, 0});
    vecs.push_back('{"st_f3b2", 1, 0, 3'b100, 32'h400, 64'h0000_0000_0000_00FF, 64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"ld_111",  0, 0, 3'b111, 32'h400, 64'h0,                   64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"lwu",     0, 0, 3'b110, 32'h400, 64'h0,                   64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"fp_byte", 0, 1, 3'b000, 32'h400, 64'h0,                   64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"sd_rv32", 1, 0, 3'b011, 32'h408, 64'h0123_4567_89AB_CDEF, 64'h0,                   2'b10, 1, 0});
    vecs.push_back('{"lw_rd0",  0, 0, 3'b010, 32'h408, 64'h0,                   64'h0,                   2'b00, 3, 0});

    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_is_store = 1'b0;
    req_is_fp    = 1'b0;
    req_funct3   = '0;
    resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.handshake", 64'({req_ready, resp_valid, mem_read, mem_write}), 64'(4'b1000));
    checkOutput("reset.mem_addr", 64'(mem_addr), 64'h0);
    checkOutput("reset.mem_wdata", mem_write_data, 64'h0);
    checkOutput("reset.mem_funct3", 64'(mem_funct3), 64'h0);
    checkOutput("reset.resp", {resp_data[61:0], resp_fault}, 64'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // A rejected request must leave the memory-side address untouched
    checkOutput("hold.mem_addr", 64'(mem_addr), 64'h408);

    // Reset cutting a store in its ISSUE cycle: strobe drops and nothing is written
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_is_fp    = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h500;
    req_wdata    = 64'h0000_0000_1234_5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("issue.write", 64'({mem_read, mem_write}), 64'(2'b01));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_issue.strobes", 64'({mem_read, mem_write}), 64'h0);
    checkOutput("rst_issue.idle", 64'({req_ready, resp_valid}), 64'(2'b10));
    @(negedge clk);
    reset_n = 1'b1;
    after_rst = '{"lw_cut", 0, 0, 3'b010, 32'h500, 64'h0, 64'h0, 2'b00, 3, 0};
    applyStimulus(after_rst);

    checkOutput("strobe.max_width", 64'(max_run), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
